// File: rtl/pingpong_layer_arbiter.sv
// Ping-pong inter-layer arbiter: one producer fills a bank while one consumer
// drains the other, with per-bank fill tracking, bank routing and frame counters.
module pingpong_layer_arbiter #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    prod_enable,
  output logic                    prod_reset,
  input  logic                    prod_done,
  output logic                    cons_enable,
  output logic                    cons_reset,
  input  logic                    cons_done,
  input  logic [ADDR_WIDTH-1:0]   prod_address_a,
  input  logic [ADDR_WIDTH-1:0]   prod_address_b,
  input  logic                    prod_rden_a,
  input  logic                    prod_rden_b,
  input  logic                    prod_wren_a,
  input  logic                    prod_wren_b,
  input  logic [ADDR_WIDTH-1:0]   cons_address_a,
  input  logic [ADDR_WIDTH-1:0]   cons_address_b,
  input  logic                    cons_rden_a,
  input  logic                    cons_rden_b,
  input  logic                    cons_wren_a,
  input  logic                    cons_wren_b,
  output logic [2*ADDR_WIDTH-1:0] bank_address_a,
  output logic [2*ADDR_WIDTH-1:0] bank_address_b,
  output logic [1:0]              bank_rden_a,
  output logic [1:0]              bank_rden_b,
  output logic [1:0]              bank_wren_a,
  output logic [1:0]              bank_wren_b,
  output logic                    q_sel,
  output logic [1:0]              bank_full,
  output logic [CNT_WIDTH-1:0]    frames_produced,
  output logic [CNT_WIDTH-1:0]    frames_consumed
);

  typedef enum logic [1:0] {P_IDLE, P_RST, P_RUN} prod_state_t;
  typedef enum logic [1:0] {C_IDLE, C_RST, C_RUN} cons_state_t;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_t;

  prod_state_t          r_prod_state, w_prod_state_nxt;
  cons_state_t          r_cons_state, w_cons_state_nxt;
  bank_state_t          r_bank_state [2];
  bank_state_t          w_bank_state_nxt [2];
  logic                 r_wr_bank, w_wr_bank_nxt;
  logic                 r_rd_bank, w_rd_bank_nxt;
  logic [CNT_WIDTH-1:0] r_frames_produced, w_frames_produced_nxt;
  logic [CNT_WIDTH-1:0] r_frames_consumed, w_frames_consumed_nxt;
  logic                 r_err, w_err_nxt;
  logic                 w_prod_fin, w_cons_fin;

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prod_state      <= P_IDLE;
      r_cons_state      <= C_IDLE;
      r_bank_state[0]   <= B_EMPTY;
      r_bank_state[1]   <= B_EMPTY;
      r_wr_bank         <= 1'b0;
      r_rd_bank         <= 1'b0;
      r_frames_produced <= '0;
      r_frames_consumed <= '0;
      r_err             <= 1'b0;
    end else begin
      r_prod_state      <= w_prod_state_nxt;
      r_cons_state      <= w_cons_state_nxt;
      r_bank_state[0]   <= w_bank_state_nxt[0];
      r_bank_state[1]   <= w_bank_state_nxt[1];
      r_wr_bank         <= w_wr_bank_nxt;
      r_rd_bank         <= w_rd_bank_nxt;
      r_frames_produced <= w_frames_produced_nxt;
      r_frames_consumed <= w_frames_consumed_nxt;
      r_err             <= w_err_nxt;
    end
  end

  // Next-state: launches claim a bank, done pulses release it
  always_comb begin
    w_prod_state_nxt      = r_prod_state;
    w_cons_state_nxt      = r_cons_state;
    w_bank_state_nxt[0]   = r_bank_state[0];
    w_bank_state_nxt[1]   = r_bank_state[1];
    w_wr_bank_nxt         = r_wr_bank;
    w_rd_bank_nxt         = r_rd_bank;
    w_frames_produced_nxt = r_frames_produced;
    w_frames_consumed_nxt = r_frames_consumed;
    w_err_nxt             = r_err;
    w_prod_fin            = (r_prod_state == P_RUN) && prod_done;
    w_cons_fin            = (r_cons_state == C_RUN) && cons_done;

    case (r_prod_state)
      P_IDLE: if (enable && (r_bank_state[r_wr_bank] == B_EMPTY)) begin
        w_prod_state_nxt               = P_RST;
        w_bank_state_nxt[r_wr_bank]    = B_FILLING;
      end
      P_RST:   w_prod_state_nxt = P_RUN;
      P_RUN:   if (prod_done) w_prod_state_nxt = P_IDLE;
      default: w_prod_state_nxt = P_IDLE;
    endcase

    case (r_cons_state)
      C_IDLE: if (enable && (r_bank_state[r_rd_bank] == B_FULL)) begin
        w_cons_state_nxt               = C_RST;
        w_bank_state_nxt[r_rd_bank]    = B_DRAINING;
      end
      C_RST:   w_cons_state_nxt = C_RUN;
      C_RUN:   if (cons_done) w_cons_state_nxt = C_IDLE;
      default: w_cons_state_nxt = C_IDLE;
    endcase

    if (w_cons_fin) begin
      w_bank_state_nxt[r_rd_bank] = B_EMPTY;
      w_rd_bank_nxt               = ~r_rd_bank;
      w_frames_consumed_nxt       = r_frames_consumed + CNT_WIDTH'(1);
    end
    // Producer update applied last so it wins a same-bank collision
    if (w_prod_fin) begin
      w_bank_state_nxt[r_wr_bank] = B_FULL;
      w_wr_bank_nxt               = ~r_wr_bank;
      w_frames_produced_nxt       = r_frames_produced + CNT_WIDTH'(1);
      if (w_cons_fin && (r_wr_bank == r_rd_bank)) w_err_nxt = 1'b1;
    end
  end

  assign prod_reset      = (r_prod_state == P_RST);
  assign prod_enable     = (r_prod_state == P_RUN);
  assign cons_reset      = (r_cons_state == C_RST);
  assign cons_enable     = (r_cons_state == C_RUN);
  assign q_sel           = r_rd_bank;
  assign frames_produced = r_frames_produced;
  assign frames_consumed = r_frames_consumed;

  // Per-bank routing: filling bank to producer, draining bank to consumer
  for (genvar gi = 0; gi < 2; gi++) begin : g_route
    logic w_fill, w_drain;
    assign w_fill        = (r_bank_state[gi] == B_FILLING);
    assign w_drain       = (r_bank_state[gi] == B_DRAINING);
    assign bank_full[gi] = (r_bank_state[gi] == B_FULL) || w_drain;
    assign bank_address_a[gi*ADDR_WIDTH +: ADDR_WIDTH] =
      w_fill ? prod_address_a : (w_drain ? cons_address_a : '0);
    assign bank_address_b[gi*ADDR_WIDTH +: ADDR_WIDTH] =
      w_fill ? prod_address_b : (w_drain ? cons_address_b : '0);
    assign bank_rden_a[gi] = (w_fill & prod_rden_a) | (w_drain & cons_rden_a);
    assign bank_rden_b[gi] = (w_fill & prod_rden_b) | (w_drain & cons_rden_b);
    assign bank_wren_a[gi] = (w_fill & prod_wren_a) | (w_drain & cons_wren_a);
    assign bank_wren_b[gi] = (w_fill & prod_wren_b) | (w_drain & cons_wren_b);
  end

endmodule

// File: doc/pingpong_layer_arbiter.md
Name: pingpong_layer_arbiter

Overview:
- Sequences one producer layer (e.g. layer_2) and one consumer layer (e.g. fc_layer_1) through a two-bank ping-pong feature buffer.
- Producer writes bank N while the consumer drains bank N^1.
- Owns each layer's enable/reset, routes address/rden/wren from the active layer to each bank, and tracks per-bank fill state.
- Sits between two layer instances in cnp, replacing single-buffer inter-layer control where overlap of consecutive frames is wanted.

Parameters:
- ADDR_WIDTH, 9, bank address width.
- CNT_WIDTH, 16, width of frame counters.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run permission; low blocks new job launches
- prod_enable  out  1  producer layer enable
- prod_reset  out  1  producer layer reset, active-high 1-cycle pulse
- prod_done  in  1  producer finished one frame, 1-cycle pulse
- cons_enable  out  1  consumer layer enable
- cons_reset  out  1  consumer layer reset, active-high 1-cycle pulse
- cons_done  in  1  consumer finished one frame, 1-cycle pulse
- prod_address_a, prod_address_b  in  ADDR_WIDTH each  producer bank addresses
- prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b  in  1 each  producer strobes
- cons_address_a, cons_address_b  in  ADDR_WIDTH each  consumer bank addresses
- cons_rden_a, cons_rden_b, cons_wren_a, cons_wren_b  in  1 each  consumer strobes
- bank_address_a, bank_address_b  out  2*ADDR_WIDTH each  per-bank address; bank i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- bank_rden_a, bank_rden_b, bank_wren_a, bank_wren_b  out  2 each  per-bank strobes, bit i = bank i
- q_sel  out  1  bank the consumer reads; drives the external q mux
- bank_full  out  2  bit i set while bank i holds an undrained frame
- frames_produced, frames_consumed  out  CNT_WIDTH each  wrapping frame counters

Behaviour:
- Reset (reset=0, async): prod/cons FSMs go to IDLE; wr_bank=0, rd_bank=0; both banks EMPTY; all outputs 0; counters 0.
- Per-bank state: EMPTY, FILLING, FULL, DRAINING. bank_full[i] = (FULL or DRAINING).
- Producer FSM:
  - P_IDLE -> P_RST when enable=1 and bank[wr_bank]=EMPTY; bank becomes FILLING.
  - P_RST: prod_reset=1 for exactly one cycle -> P_RUN.
  - P_RUN: prod_enable=1 until prod_done is sampled. On prod_done: bank[wr_bank] becomes FULL, wr_bank toggles, frames_produced increments, FSM -> P_IDLE.
  - prod_enable is low in the cycle after the done edge.
- Consumer FSM: same structure (C_IDLE/C_RST/C_RUN), launching when enable=1 and bank[rd_bank]=FULL. FULL becomes DRAINING; on cons_done the bank becomes EMPTY, rd_bank toggles, frames_consumed increments.
- Latency:
  - Launch condition true at edge k -> reset pulse in cycle k+1, enable high from cycle k+2.
  - prod_done at edge t -> bank FULL at t+1 -> cons_reset in cycle t+2, cons_enable from t+3, provided the consumer is idle.
- Routing (combinational from registered state):
  - FILLING bank gets prod_* address and strobes.
  - DRAINING bank gets cons_*.
  - EMPTY/FULL banks: address 0, strobes 0.
  - q_sel = rd_bank.
  - A bank is never routed to both layers.
- enable=0: no launches; a job already in P_RUN/C_RUN continues to completion. Done pulses are always honoured.
- Simultaneous prod_done and cons_done in the same cycle: both updates apply. If both target the same bank (impossible by construction), the producer transition wins and an internal sticky error flag is set (verification-visible via hierarchy).
- Done pulse while FSM is not in RUN: ignored, no state change.
- Both banks FULL: producer waits in P_IDLE (back-pressure). Both banks EMPTY: consumer waits.
- Counters wrap from 2^CNT_WIDTH-1 to 0.
- Reset deassert mid-frame is not special: async assertion anywhere returns the block to the reset state on that edge; layers see enable/reset 0.

Test Plan:
- Reset then enable=1, bank0 EMPTY -> prod_reset=1 in cycle 1, prod_enable=1 from cycle 2; bank_wren_a[0] follows prod_wren_a; bank 1 strobes 0.
- prod_done at cycle 10 -> prod_enable=0 at 11, bank_full=01, cons_reset at 12, cons_enable from 13, q_sel=0. Producer relaunches on bank1: prod_reset at 12.
- Consumer held (no cons_done) while producer finishes bank1 -> bank_full=11; producer stays P_IDLE, prod_enable=0 until cons_done. Then bank0 refilled, frames_produced=3 after the third done.
- prod_done and cons_done in the same cycle -> wr_bank and rd_bank both toggle; frames_produced and frames_consumed both increment by 1; no error flag.
- enable dropped during P_RUN -> run completes on prod_done; no further prod_reset while enable=0.
- reset asserted during C_RUN -> all outputs 0 immediately; counters 0; bank_full=00.
- Counters preset near wrap via force at 16'hFFFF plus one done -> counter reads 0.
